axi_burst_master: RTL

- AXI-style master that sits directly upstream of axi_memory in the accelerator datapath.
- Accepts one command at a time from the accelerator control logic: a write burst or a read sequence.
- Write commands become one incrementing AW burst followed by W beats and a B response; the write data comes from a valid/ready stream.
- Read commands become a sequence of single-beat AR/R transactions at incrementing word addresses; the read data goes out on a valid/ready stream.
- Drives the memory's W_EN/R_EN enables.

---
 rtl/axi_burst_master.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/axi_burst_master.sv
// axi_burst_master: single-outstanding AXI-style master in front of axi_memory.
// Runs one command at a time. A write command issues one incrementing AW
// burst, streams the W beats from the wr_* stream, then waits for B. A read
// command issues single-beat AR/R pairs at incrementing word addresses and
// streams the results out on rd_*.
//
// Ports:
//   ACLK, ARESETn          clock, asynchronous active-low reset
//   cmd_*                  command request (write/read, start address, beat count)
//   wr_valid/ready/data    write-data stream in
//   rd_valid/ready/data    read-data stream out
//   done                   one-cycle completion pulse
//   err                    sticky response error, cleared on next command accept
//   AW*/W*/B*/AR*/R*       AXI-style channels to the memory
//   W_EN, R_EN             memory write/read enables
module axi_burst_master #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [1:0]  RESP_OK    = 2'b01
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]            cmd_len,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  done,
  output logic                  err,
  output logic                  AWVALID,
  input  logic                  AWREADY,
  output logic [ADDR_WIDTH-1:0] AWADDR,
  output logic                  AWBURST,
  output logic [7:0]            AWLEN,
  output logic                  WVALID,
  input  logic                  WREADY,
  output logic [DATA_WIDTH-1:0] WDATA,
  output logic                  WLAST,
  input  logic                  BVALID,
  output logic                  BREADY,
  input  logic [1:0]            BRESP,
  output logic                  ARVALID,
  input  logic                  ARREADY,
  output logic [ADDR_WIDTH-1:0] ARADDR,
  input  logic                  RVALID,
  output logic                  RREADY,
  input  logic [DATA_WIDTH-1:0] RDATA,
  input  logic [1:0]            RRESP,
  output logic                  W_EN,
  output logic                  R_EN
);

  typedef enum logic [2:0] {
    IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA, DONE
  } state_t;

  state_t                  state, state_next;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [7:0]              len_q;
  logic [7:0]              cnt_q;
  logic [7:0]              cnt_inc;
  logic                    last_beat;
  logic                    accept, w_hs, r_hs;

  // The current beat is the last one when one more beat reaches len.
  assign cnt_inc   = cnt_q + 8'd1;
  assign last_beat = (cnt_inc == len_q);

  assign accept = (state == IDLE)    && cmd_valid;
  assign w_hs   = (state == WR_DATA) && wr_valid && WREADY;
  assign r_hs   = (state == RD_DATA) && RVALID && rd_ready;

  assign AWADDR = addr_q;
  assign ARADDR = addr_q;
  assign AWLEN  = len_q;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    cmd_ready  = 1'b0;
    wr_ready   = 1'b0;
    rd_valid   = 1'b0;
    rd_data    = '0;
    WVALID     = 1'b0;
    WDATA      = '0;
    WLAST      = 1'b0;
    BREADY     = 1'b0;
    RREADY     = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          if (cmd_len == 8'd0) state_next = DONE;
          else if (cmd_write)  state_next = WR_ADDR;
          else                 state_next = RD_ADDR;
        end
      end
      WR_ADDR: if (AWREADY) state_next = WR_DATA;
      WR_DATA: begin
        WVALID   = wr_valid;
        WDATA    = wr_data;
        wr_ready = WREADY;
        WLAST    = last_beat;
        if (w_hs && last_beat) state_next = WR_RESP;
      end
      WR_RESP: begin
        BREADY = 1'b1;
        if (BVALID) state_next = DONE;
      end
      RD_ADDR: if (ARREADY) state_next = RD_DATA;
      RD_DATA: begin
        RREADY   = rd_ready;
        rd_valid = RVALID;
        rd_data  = RDATA;
        if (r_hs) state_next = last_beat ? DONE : RD_ADDR;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Channel valids and enables are registered from the next state so they
  // rise on state entry and fall on the edge that completes the handshake.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      AWVALID <= 1'b0;
      AWBURST <= 1'b0;
      ARVALID <= 1'b0;
      W_EN    <= 1'b0;
      R_EN    <= 1'b0;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      err     <= 1'b0;
    end else begin
      AWVALID <= (state_next == WR_ADDR);
      AWBURST <= (state_next == WR_ADDR);
      ARVALID <= (state_next == RD_ADDR);
      W_EN    <= (state_next inside {WR_ADDR, WR_DATA, WR_RESP});
      R_EN    <= (state_next inside {RD_ADDR, RD_DATA});
      if (accept) begin
        addr_q <= cmd_addr;
        len_q  <= cmd_len;
        cnt_q  <= '0;
        err    <= 1'b0;
      end
      if (w_hs) cnt_q <= last_beat ? 8'd0 : cnt_inc;
      if ((state == WR_RESP) && BVALID && (BRESP != RESP_OK)) err <= 1'b1;
      if (r_hs) begin
        if (RRESP != RESP_OK) err <= 1'b1;
        addr_q <= addr_q + ADDR_WIDTH'(1);
        cnt_q  <= last_beat ? 8'd0 : cnt_inc;
      end
    end
  end

endmodule
